// File: rtl/spram64x16_arb_pkg.sv
// Shared constants and types for the spram64x16 sequencer/arbiter.
// Holds geometry, FSM state encoding and the requester index type.
package spram64x16_arb_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef logic req_idx_t;

endpackage

// File: rtl/spram64x16_arb_rr_arb2.sv
// Two-input round-robin grant unit.
// Ports: valid[1:0] requests, rr_ptr = last granted index, gnt[1:0] one-hot grant.
module rr_arb2
    import spram64x16_arb_pkg::*;
(
    input  logic [1:0] valid,
    input  req_idx_t   rr_ptr,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        unique case (valid)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            // On contention the requester that did not win last time goes first.
            2'b11:   gnt = rr_ptr ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/spram64x16_arb.sv
// Fill sequencer and two-port round-robin arbiter in front of a 64x16 SPRAM.
// Ports: clk/rst, clr_req, init_done, req0/req1 command + rsp0/rsp1 read data, mem_* SRAM pins.
module spram64x16_arb
    import spram64x16_arb_pkg::*;
#(
    parameter int                      ADDR_W        = spram64x16_arb_pkg::ADDR_W,
    parameter int                      DATA_W        = spram64x16_arb_pkg::DATA_W,
    parameter logic [DATA_W-1:0]       INIT_VAL      = '0,
    parameter bit                      INIT_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              init_done,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,

    output logic              mem_ceb,
    output logic              mem_web,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_d,
    input  logic [DATA_W-1:0] mem_q
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    req_idx_t          rr_q, rr_d;
    logic              rsp0_valid_q, rsp0_valid_d;
    logic              rsp1_valid_q, rsp1_valid_d;
    logic              init_done_q, init_done_d;

    logic       arb_en;
    logic [1:0] arb_valid;
    logic [1:0] gnt;

    // Arbitration only runs in RUN with no clear pending; reset holds ports idle.
    assign arb_en    = !rst && (state_q == ST_RUN) && !clr_req;
    assign arb_valid = {req1_valid, req0_valid} & {2{arb_en}};

    rr_arb2 u_rr_arb2 (
        .valid  (arb_valid),
        .rr_ptr (rr_q),
        .gnt    (gnt)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rr_d         = rr_q;
        rsp0_valid_d = 1'b0;
        rsp1_valid_d = 1'b0;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        mem_ceb      = 1'b1;
        mem_web      = 1'b1;
        mem_a        = '0;
        mem_d        = '0;

        if (!rst) begin
            unique case (state_q)
                ST_INIT: begin
                    mem_ceb = 1'b0;
                    mem_web = 1'b0;
                    mem_a   = cnt_q;
                    mem_d   = INIT_VAL;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == '1) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end
                end
                ST_RUN: begin
                    if (clr_req) begin
                        state_d = ST_INIT;
                        cnt_d   = '0;
                    end else if (gnt[0]) begin
                        req0_ready   = 1'b1;
                        mem_ceb      = 1'b0;
                        mem_web      = ~req0_we;
                        mem_a        = req0_addr;
                        mem_d        = req0_wdata;
                        rr_d         = 1'b0;
                        rsp0_valid_d = ~req0_we;
                    end else if (gnt[1]) begin
                        req1_ready   = 1'b1;
                        mem_ceb      = 1'b0;
                        mem_web      = ~req1_we;
                        mem_a        = req1_addr;
                        mem_d        = req1_wdata;
                        rr_d         = 1'b1;
                        rsp1_valid_d = ~req1_we;
                    end
                end
                default: begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end
            endcase
        end

        init_done_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= INIT_ON_RESET ? ST_INIT : ST_RUN;
            cnt_q        <= '0;
            rr_q         <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            init_done_q  <= ~INIT_ON_RESET;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rr_q         <= rr_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            init_done_q  <= init_done_d;
        end
    end

    assign init_done  = init_done_q;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    // The SRAM returns data for the read issued last cycle; steer it to its owner.
    assign rsp0_rdata = rsp0_valid_q ? mem_q : '0;
    assign rsp1_rdata = rsp1_valid_q ? mem_q : '0;

endmodule
